sysref_align_monitor: RTL and testbench

//  Sits directly downstream of the PL SYSREF capture flop and consumes its registered sysref_adc.
//  - Detects SYSREF rising edges and measures the period in pl_clk cycles.
//  - Declares lock after a run of consistent periods.
//  - Keeps a local phase counter aligned to SYSREF, counts misaligned or missing edges.
//  - Issues a one-shot sync_pulse on the first aligned edge after software arms it.

---
 rtl/sysref_align_monitor.sv | 127 ++++++++++++
 tb/tb_sysref_align_monitor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sysref_align_monitor.sv
// sysref_align_monitor: measures the SYSREF period, locks onto it, tracks the local phase against
// SYSREF and counts edges that are misaligned or missing. It also issues a one-shot armed sync pulse.
module sysref_align_monitor #(
    parameter int CNT_W      = 16,
    parameter int PERIOD_MIN = 4,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 1
) (
    input  logic             pl_clk,
    input  logic             pl_resetn,
    input  logic             sysref_adc,
    input  logic             arm,
    output logic             sysref_edge,
    output logic             sync_pulse,
    output logic             armed,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] lmfc_cnt,
    output logic [7:0]       err_cnt
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] ONES  = '1;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TOL_W = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] PMIN  = CNT_W'(PERIOD_MIN);
    localparam logic [MW-1:0]    LC    = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    state_t           state, state_n;
    logic             sysref_d, rise, valid, near_ref, aligned, overdue, fire, inc_err, armed_n;
    logic [CNT_W-1:0] pcnt, ref_p, ref_n, period_n, lmfc_n, d_ref, d_per;
    logic [MW-1:0]    match_cnt, match_n;

    assign rise     = sysref_adc & ~sysref_d;
    assign valid    = (pcnt >= PMIN) && (pcnt != ONES);
    assign d_ref    = (pcnt >= ref_p) ? pcnt - ref_p : ref_p - pcnt;
    assign d_per    = (pcnt >= period) ? pcnt - period : period - pcnt;
    assign near_ref = d_ref <= TOL_W;
    assign aligned  = d_per <= TOL_W;
    // widened so period+TOL cannot wrap near the top of the counter range
    assign overdue  = {1'b0, pcnt} > ({1'b0, period} + {1'b0, TOL_W});

    always_comb begin
        state_n  = state;
        match_n  = match_cnt;
        ref_n    = ref_p;
        period_n = period;
        lmfc_n   = '0;
        fire     = 1'b0;
        inc_err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_n = MEASURE;
                    match_n = '0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (!valid) begin
                        match_n = '0;
                    end else if (match_cnt == '0 || !near_ref) begin
                        ref_n   = pcnt;
                        match_n = MW'(1);
                    end else begin
                        match_n = match_cnt + MW'(1);
                    end
                    if (match_n == LC) begin
                        state_n  = LOCKED;
                        period_n = ref_n;
                    end
                end
            end
            LOCKED: begin
                lmfc_n = (lmfc_cnt + ONE == period) ? '0 : lmfc_cnt + ONE;
                if (rise && aligned) begin
                    lmfc_n = '0;
                    fire   = armed;
                end else if (rise) begin
                    inc_err = 1'b1;
                    state_n = MEASURE;
                    ref_n   = pcnt;
                    match_n = valid ? MW'(1) : '0;
                    lmfc_n  = '0;
                end else if (overdue) begin
                    inc_err = 1'b1;
                    state_n = IDLE;
                    lmfc_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        // a request only survives while lock is held; arm on the firing edge re-arms for the next one
        armed_n = (state == LOCKED) && (state_n == LOCKED) && (arm || (armed && !fire));
    end

    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) begin
            state       <= IDLE;
            sysref_d    <= 1'b1;
            pcnt        <= '0;
            match_cnt   <= '0;
            ref_p       <= '0;
            period      <= '0;
            lmfc_cnt    <= '0;
            err_cnt     <= '0;
            locked      <= 1'b0;
            armed       <= 1'b0;
            sysref_edge <= 1'b0;
            sync_pulse  <= 1'b0;
        end else begin
            state       <= state_n;
            sysref_d    <= sysref_adc;
            pcnt        <= rise ? ONE : (pcnt == ONES ? pcnt : pcnt + ONE);
            match_cnt   <= match_n;
            ref_p       <= ref_n;
            period      <= period_n;
            lmfc_cnt    <= lmfc_n;
            err_cnt     <= (inc_err && err_cnt != 8'hff) ? err_cnt + 8'd1 : err_cnt;
            locked      <= state_n == LOCKED;
            armed       <= armed_n;
            sysref_edge <= rise;
            sync_pulse  <= fire;
        end
    end
endmodule

// File: tb/tb_sysref_align_monitor.sv
// tb_sysref_align_monitor: directed and random SYSREF trains checked cycle by cycle against a
// reference model built from edge gaps, lock streaks and phase arithmetic.
module tb_sysref_align_monitor;
    logic        pl_clk, pl_resetn, sysref_adc, arm;
    logic        sysref_edge, sync_pulse, armed, locked;
    logic [15:0] period, lmfc_cnt;
    logic [7:0]  err_cnt;

    int checks = 0, failures = 0, nsync = 0;
    int m_prev, m_gap, m_mode, m_streak, m_ref, m_period, m_phase, m_err, m_armed, m_edge, m_sync;

    sysref_align_monitor dut (
        .pl_clk(pl_clk), .pl_resetn(pl_resetn), .sysref_adc(sysref_adc), .arm(arm),
        .sysref_edge(sysref_edge), .sync_pulse(sync_pulse), .armed(armed), .locked(locked),
        .period(period), .lmfc_cnt(lmfc_cnt), .err_cnt(err_cnt)
    );

    initial pl_clk = 0;
    always #5 pl_clk = ~pl_clk;

    function automatic int iabs(input int x);
        return x < 0 ? -x : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 1; m_gap = 0; m_mode = 0; m_streak = 0; m_ref = 0; m_period = 0;
        m_phase = 0; m_err = 0; m_armed = 0; m_edge = 0; m_sync = 0;
    endtask

    // modes: 0 waiting for a first edge, 1 measuring, 2 locked
    task automatic model_step(input logic s, input logic a);
        bit rise = s && !m_prev;
        int g    = m_gap;
        bit ok   = g >= 4 && g != 65535;
        bit was  = m_mode == 2;
        m_prev = s; m_edge = rise; m_sync = 0;
        if (m_mode == 0) begin
            if (rise) begin m_mode = 1; m_streak = 0; end
        end else if (m_mode == 1) begin
            if (rise) begin
                if (!ok) m_streak = 0;
                else if (m_streak == 0 || iabs(g - m_ref) > 1) begin m_ref = g; m_streak = 1; end
                else m_streak++;
                if (m_streak == 4) begin m_mode = 2; m_period = m_ref; m_phase = 0; end
            end
        end else begin
            if (rise && iabs(g - m_period) <= 1) begin
                m_phase = 0;
                if (m_armed) begin m_sync = 1; m_armed = 0; end
            end else if (rise) begin
                if (m_err < 255) m_err++;
                m_mode = 1; m_ref = g; m_streak = ok ? 1 : 0;
            end else if (g > m_period + 1) begin
                if (m_err < 255) m_err++;
                m_mode = 0;
            end else m_phase = (m_phase + 1) % m_period;
        end
        if (m_mode != 2) begin m_armed = 0; m_phase = 0; end
        else if (was && a) m_armed = 1;
        m_gap = rise ? 1 : (g < 65535 ? g + 1 : g);
    endtask

    task automatic compare_all();
        chk("sysref_edge", 32'(sysref_edge), 32'(m_edge));
        chk("sync_pulse", 32'(sync_pulse), 32'(m_sync));
        chk("armed", 32'(armed), 32'(m_armed));
        chk("locked", 32'(locked), 32'(m_mode == 2));
        chk("period", 32'(period), 32'(m_period));
        chk("lmfc_cnt", 32'(lmfc_cnt), 32'(m_phase));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    task automatic tick(input logic s, input logic a);
        sysref_adc = s;
        arm = a;
        @(posedge pl_clk);
        model_step(s, a);
        #1;
        compare_all();
        nsync += 32'(sync_pulse);
    endtask

    task automatic run_period(input int p, input int arm_pos);
        int h = p >= 8 ? 4 : (p + 1) / 2;
        for (int i = 0; i < p; i++) tick(i < h, i == arm_pos);
    endtask

    initial begin
        int opts[6] = '{16, 16, 17, 15, 19, 0};
        pl_resetn = 0; sysref_adc = 1; arm = 0;
        model_reset();
        repeat (3) @(posedge pl_clk);
        #1;
        compare_all();
        pl_resetn = 1;
        repeat (10) tick(1, 0);
        chk("hold_high_no_edge_err", 32'(err_cnt), 0);
        repeat (5) tick(0, 0);
        repeat (4) run_period(16, -1);
        chk("not_locked_after4", 32'(locked), 0);
        run_period(16, -1);
        chk("locked_after5", 32'(locked), 1);
        chk("period16", 32'(period), 16);
        chk("lmfc_end", 32'(lmfc_cnt), 15);
        run_period(17, -1);
        run_period(16, -1);
        chk("tol17_locked", 32'(locked), 1);
        chk("tol17_err", 32'(err_cnt), 0);
        run_period(19, -1);
        chk("p19_unlocked", 32'(locked), 0);
        chk("p19_err", 32'(err_cnt), 1);
        repeat (4) run_period(16, -1);
        chk("relock_pending", 32'(locked), 0);
        run_period(16, -1);
        chk("relocked", 32'(locked), 1);
        nsync = 0;
        run_period(16, 7);
        run_period(16, -1);
        run_period(16, -1);
        chk("arm_mid_one_sync", 32'(nsync), 1);
        nsync = 0;
        run_period(16, 0);
        chk("arm_on_edge_no_fire", 32'(nsync), 0);
        run_period(16, -1);
        run_period(16, -1);
        chk("arm_on_edge_next_sync", 32'(nsync), 1);
        repeat (30) tick(0, 0);
        chk("stop_unlocked", 32'(locked), 0);
        chk("stop_err", 32'(err_cnt), 2);
        repeat (20) run_period(3, -1);
        chk("p3_never_locks", 32'(locked), 0);
        for (int n = 0; n < 60; n++) begin
            int p = opts[$urandom_range(0, 5)];
            if (p == 0) p = $urandom_range(2, 24);
            run_period(p, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, p - 1)) : -1);
        end
        repeat (6) run_period(16, -1);
        chk("final_locked", 32'(locked), 1);
        run_period(16, 5);
        repeat (3) tick(1, 0);
        #2;
        pl_resetn = 0;
        #1;
        model_reset();
        compare_all();
        chk("async_reset_locked", 32'(locked), 0);
        @(posedge pl_clk);
        #2;
        pl_resetn = 1;
        repeat (5) tick(0, 0);
        repeat (6) run_period(16, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
